// File: rtl/fpu_dp_unpack.sv
// fpu_dp_unpack: iterative double-precision operand unpacker.
// Classifies a 64-bit IEEE-754 double and produces a signed unbiased exponent
// and a 53-bit significand with the integer bit (52) set for finite non-zero
// values. Subnormals are normalized by a multi-cycle leading-zero shifter that
// moves at most SHIFT_STEP bits per cycle.
//
// Optional build macro: FPU_UNPACK_DAZ_EN (denormals-are-zero). When defined,
// subnormal inputs decode as ZERO and never enter the normalizer, but
// fullClass_o still reports them as subnormal.
//
// class_o one-hot layout (shared FPU class flags):
//   bit 0 NORM, bit 1 ZERO, bit 2 INF, bit 3 SNAN, bit 4 QNAN, bit 5 reserved (never set)
//
// state | meaning
// IDLE  | ready for an operand
// NORM  | shifting a subnormal significand toward bit 52
// DONE  | result valid, held until out_ready_i
module fpu_dp_unpack #(
    parameter int SHIFT_STEP = 8,
    parameter int TAG_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [63:0]      rs1_i,
    input  logic [2:0]       rm_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      rs1_o,
    output logic [2:0]       rm_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [12:0]      exp_o,
    output logic [52:0]      sig_o,
    output logic [5:0]       class_o,
    output logic [9:0]       fullClass_o
);

    localparam logic [5:0] CLS_NORM = 6'b000001;
    localparam logic [5:0] CLS_ZERO = 6'b000010;
    localparam logic [5:0] CLS_INF  = 6'b000100;
    localparam logic [5:0] CLS_SNAN = 6'b001000;
    localparam logic [5:0] CLS_QNAN = 6'b010000;

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t      state;

    logic        s_in;
    logic [10:0] e_in;
    logic [51:0] f_in;

    logic [5:0]  dec_class;
    logic [12:0] dec_exp;
    logic [52:0] dec_sig;
    logic [9:0]  dec_full;
    logic        dec_sub;

    logic [5:0]  lz;
    logic        lz_found;

    assign s_in = rs1_i[63];
    assign e_in = rs1_i[62:52];
    assign f_in = rs1_i[51:0];

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    // Decode the incoming operand into class, exponent and significand.
    always_comb begin
        dec_class = '0;
        dec_exp   = '0;
        dec_sig   = '0;
        dec_full  = '0;
        dec_sub   = 1'b0;
        if (e_in == 11'h7FF) begin
            if (f_in != '0) begin
                if (f_in[51]) begin
                    dec_class = CLS_QNAN;
                    dec_full  = 10'h200;
                end else begin
                    dec_class = CLS_SNAN;
                    dec_full  = 10'h100;
                end
            end else begin
                dec_class = CLS_INF;
                dec_full  = s_in ? 10'h001 : 10'h080;
            end
        end else if (e_in == 11'h000) begin
            if (f_in == '0) begin
                dec_class = CLS_ZERO;
                dec_full  = s_in ? 10'h008 : 10'h010;
            end else begin
                dec_full = s_in ? 10'h004 : 10'h020;
`ifdef FPU_UNPACK_DAZ_EN
                dec_class = CLS_ZERO;
`else
                // Start at the subnormal exponent; the normalizer subtracts its shifts.
                dec_class = CLS_NORM;
                dec_exp   = 13'(-1022);
                dec_sig   = {1'b0, f_in};
                dec_sub   = 1'b1;
`endif
            end
        end else begin
            dec_class = CLS_NORM;
            dec_exp   = {2'b00, e_in} - 13'd1023;
            dec_sig   = {1'b1, f_in};
            dec_full  = s_in ? 10'h002 : 10'h040;
        end
    end

    // Leading zeros of the working significand, clamped to SHIFT_STEP.
    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (!lz_found) begin
                if (sig_o[52-i]) lz_found = 1'b1;
                else             lz = lz + 6'd1;
            end
        end
    end

    // Control FSM; sig_o/exp_o double as the normalizer working registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rs1_o       <= '0;
            rm_o        <= '0;
            tag_o       <= '0;
            exp_o       <= '0;
            sig_o       <= '0;
            class_o     <= '0;
            fullClass_o <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        rs1_o       <= rs1_i;
                        rm_o        <= rm_i;
                        tag_o       <= tag_i;
                        exp_o       <= dec_exp;
                        sig_o       <= dec_sig;
                        class_o     <= dec_class;
                        fullClass_o <= dec_full;
                        state       <= dec_sub ? NORM : DONE;
                    end
                end
                NORM: begin
                    sig_o <= sig_o << lz;
                    exp_o <= exp_o - {7'd0, lz};
                    if (lz < STEP) state <= DONE;
                end
                DONE: begin
                    if (out_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_dp_unpack.sv
// Testbench for fpu_dp_unpack: directed vectors checked against a
// value-level model of IEEE-754 double classification.
module tb_fpu_dp_unpack;

    localparam int SS = 8;
    localparam int TW = 5;

    localparam logic [5:0] C_NORM = 6'b000001;
    localparam logic [5:0] C_ZERO = 6'b000010;
    localparam logic [5:0] C_INF  = 6'b000100;
    localparam logic [5:0] C_SNAN = 6'b001000;
    localparam logic [5:0] C_QNAN = 6'b010000;

    logic          clk_i = 1'b0;
    logic          rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [63:0]   rs1_i, rs1_o;
    logic [2:0]    rm_i, rm_o;
    logic [TW-1:0] tag_i, tag_o;
    logic [12:0]   exp_o;
    logic [52:0]   sig_o;
    logic [5:0]    class_o;
    logic [9:0]    fullClass_o;

    fpu_dp_unpack #(.SHIFT_STEP(SS), .TAG_W(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .rs1_i(rs1_i), .rm_i(rm_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .rs1_o(rs1_o), .rm_o(rm_o), .tag_o(tag_o),
        .exp_o(exp_o), .sig_o(sig_o), .class_o(class_o), .fullClass_o(fullClass_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0]   raw;
        logic [2:0]    rm;
        logic [TW-1:0] tag;
        logic [5:0]    cls;
        logic [12:0]   exp;
        logic [52:0]   sig;
        logic [9:0]    fc;
        int            lat;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_lat = -1;
    bit prev_valid = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Value-level model: a subnormal is F * 2^-1074; normalizing puts its top
    // set bit at position 52, and the shifter walks SS bits per cycle.
    function automatic exp_t model(input logic [63:0] x);
        exp_t m;
        int e = int'(x[62:52]);
        logic [51:0] f = x[51:0];
        bit s = x[63];
        int p = 0;
        m.raw = x; m.rm = '0; m.tag = '0;
        m.cls = '0; m.exp = '0; m.sig = '0; m.fc = '0; m.lat = 1;
        if (e == 2047) begin
            if (f == 0) begin m.cls = C_INF; m.fc = s ? 10'h001 : 10'h080; end
            else if (f[51]) begin m.cls = C_QNAN; m.fc = 10'h200; end
            else begin m.cls = C_SNAN; m.fc = 10'h100; end
        end else if (e == 0 && f == 0) begin
            m.cls = C_ZERO; m.fc = s ? 10'h008 : 10'h010;
        end else if (e == 0) begin
            m.fc = s ? 10'h004 : 10'h020;
`ifdef FPU_UNPACK_DAZ_EN
            m.cls = C_ZERO;
`else
            for (int i = 0; i < 52; i++) if (f[i]) p = i;
            m.cls = C_NORM;
            m.exp = 13'(p - 1074);
            m.sig = 53'(f) << (52 - p);
            m.lat = 1 + ((52 - p) / SS + 1);
`endif
        end else begin
            m.cls = C_NORM;
            m.exp = 13'(e - 1023);
            m.sig = {1'b1, f};
            m.fc  = s ? 10'h002 : 10'h040;
        end
        return m;
    endfunction

    // Compare process: every valid cycle is checked against the queue head.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid_i && in_ready_o && !flush_i) acc_cyc = cyc;
            if (out_valid_o) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 64'(out_valid_o), 64'd0);
                end else begin
                    if (!prev_valid) begin
                        last_lat = cyc - acc_cyc;
                        check("latency", 64'(last_lat), 64'(q[0].lat));
                    end
                    check("rs1", rs1_o, q[0].raw);
                    check("rm", 64'(rm_o), 64'(q[0].rm));
                    check("tag", 64'(tag_o), 64'(q[0].tag));
                    check("class", 64'(class_o), 64'(q[0].cls));
                    check("exp", 64'(exp_o), 64'(q[0].exp));
                    check("sig", 64'(sig_o), 64'(q[0].sig));
                    check("fullclass", 64'(fullClass_o), 64'(q[0].fc));
                    if (out_ready_i) void'(q.pop_front());
                end
            end
            prev_valid = out_valid_o;
        end
    end

    task automatic send(input logic [63:0] x, input logic [2:0] rm, input logic [TW-1:0] tg, input int hold);
        exp_t m;
        int n;
        m = model(x);
        m.rm = rm;
        m.tag = tg;
        q.push_back(m);
        rs1_i = x; rm_i = rm; tag_i = tg; in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
        check("accept_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 40) begin @(posedge clk_i); #1; n++; end
        check("valid_timeout", 64'(out_valid_o), 64'd1);
        if (!out_valid_o) q.delete();
        for (int i = 0; i < hold; i++) begin
            check("hold_in_ready", 64'(in_ready_o), 64'd0);
            @(posedge clk_i); #1;
        end
        check("held_valid", 64'(out_valid_o), 64'd1);
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check("idle_valid", 64'(out_valid_o), 64'd0);
        check("idle_ready", 64'(in_ready_o), 64'd1);
    endtask

    // Abort a subnormal during its third NORM cycle with reset or flush.
    task automatic abort_norm(input bit use_rst);
        exp_t m;
        m = model(64'h1);
        m.rm = 3'd1;
        m.tag = 5'd9;
        q.push_back(m);
        rs1_i = 64'h1; rm_i = 3'd1; tag_i = 5'd9; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("abort_busy_ready", 64'(in_ready_o), 64'd0);
        check("abort_busy_valid", 64'(out_valid_o), 64'd0);
        if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; flush_i = 1'b0;
        q.delete();
        check("abort_valid", 64'(out_valid_o), 64'd0);
        check("abort_ready", 64'(in_ready_o), 64'd1);
        if (use_rst) begin
            check("rst_clears_rs1", rs1_o, 64'd0);
            check("rst_clears_sig", 64'(sig_o), 64'd0);
            check("rst_clears_tag", 64'(tag_o), 64'd0);
        end else begin
            check("flush_keeps_rs1", rs1_o, 64'h1);
            check("flush_keeps_tag", 64'(tag_o), 64'd9);
        end
        repeat (10) @(posedge clk_i);
        #1;
        check("abort_no_result", 64'(out_valid_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        rs1_i = '0; rm_i = '0; tag_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_exp", 64'(exp_o), 64'd0);
        check("rst_sig", 64'(sig_o), 64'd0);
        check("rst_class", 64'(class_o), 64'd0);
        check("rst_fullclass", 64'(fullClass_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // 1.0 with a 3-cycle backpressure hold
        send(64'h3FF0000000000000, 3'd2, 5'd3, 3);
        check("one_lat", 64'(last_lat), 64'd1);
        check("one_exp", 64'(exp_o), 64'd0);
        check("one_sig", 64'(sig_o), 64'h0010000000000000);
        check("one_class", 64'(class_o), 64'(C_NORM));
        check("one_fc", 64'(fullClass_o), 64'h040);

        // smallest subnormal
        send(64'h0000000000000001, 3'd4, 5'd17, 0);
        check("min_sub_fc", 64'(fullClass_o), 64'h020);
`ifdef FPU_UNPACK_DAZ_EN
        check("min_sub_lat", 64'(last_lat), 64'd1);
        check("min_sub_class", 64'(class_o), 64'(C_ZERO));
        check("min_sub_sig", 64'(sig_o), 64'd0);
`else
        check("min_sub_lat", 64'(last_lat), 64'd8);
        check("min_sub_class", 64'(class_o), 64'(C_NORM));
        check("min_sub_exp", 64'(exp_o), 64'h1BCE);
        check("min_sub_sig", 64'(sig_o), 64'h0010000000000000);
`endif

        // largest negative subnormal
        send(64'h800FFFFFFFFFFFFF, 3'd0, 5'd5, 1);
        check("neg_sub_fc", 64'(fullClass_o), 64'h004);
`ifndef FPU_UNPACK_DAZ_EN
        check("neg_sub_lat", 64'(last_lat), 64'd2);
        check("neg_sub_exp", 64'(exp_o), 64'h1C01);
        check("neg_sub_sig", 64'(sig_o), 64'h001FFFFFFFFFFFFE);
`endif

        send(64'hFFF8000000000000, 3'd1, 5'd1, 0);
        check("qnan_class", 64'(class_o), 64'(C_QNAN));
        check("qnan_fc", 64'(fullClass_o), 64'h200);
        check("qnan_exp", 64'(exp_o), 64'd0);
        check("qnan_sig", 64'(sig_o), 64'd0);

        send(64'h7FF0000000000001, 3'd1, 5'd2, 0);
        check("snan_class", 64'(class_o), 64'(C_SNAN));
        check("snan_fc", 64'(fullClass_o), 64'h100);

        send(64'h8000000000000000, 3'd3, 5'd4, 0);
        check("negzero_class", 64'(class_o), 64'(C_ZERO));
        check("negzero_fc", 64'(fullClass_o), 64'h008);
        check("negzero_sig", 64'(sig_o), 64'd0);

        // Remaining classes and exponent extremes, checked by the model only
        send(64'h7FF0000000000000, 3'd0, 5'd6, 0);
        send(64'hFFF0000000000000, 3'd0, 5'd7, 0);
        send(64'h7FEFFFFFFFFFFFFF, 3'd2, 5'd8, 0);
        send(64'h0010000000000000, 3'd2, 5'd10, 0);
        send(64'hC004000000000000, 3'd3, 5'd11, 2);
        send(64'h0000000000000000, 3'd0, 5'd12, 0);
        send(64'h0000100000000000, 3'd4, 5'd13, 0);
        send(64'h0008000000000000, 3'd4, 5'd14, 0);
        send(64'h8000000000000100, 3'd1, 5'd15, 1);
        send(64'h0000000000800000, 3'd2, 5'd16, 0);

`ifndef FPU_UNPACK_DAZ_EN
        abort_norm(1'b1);
        abort_norm(1'b0);
`endif
        send(64'h4000000000000000, 3'd0, 5'd31, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_dp_unpack.md
Name: fpu_dp_unpack

Overview:
- Iterative double-precision operand unpacker; sits directly upstream of the double-to-single convert stage and feeds its exp/sig/class/rm inputs.
- Classifies a 64-bit IEEE-754 double and produces an unbiased signed exponent and a 53-bit significand with bit 52 always set for finite non-zero values.
- Subnormals are normalized with a multi-cycle leading-zero shifter.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- SHIFT_STEP, 8, maximum left-shift per normalization cycle; power of two, 1..32.
- TAG_W, 5, width of the destination tag carried alongside the operand.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  synchronous pipeline flush; drops any operation in flight
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block can accept an operand
- rs1_i  in  64  raw double operand
- rm_i  in  3  rounding mode, passed through
- tag_i  in  TAG_W  destination tag, passed through
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- rs1_o  out  64  latched raw operand
- rm_o  out  3  latched rounding mode
- tag_o  out  TAG_W  latched tag
- exp_o  out  13  signed unbiased exponent
- sig_o  out  53  significand, bit 52 is the integer bit
- class_o  out  6  one-hot class, encoded with the shared FPU class flag definitions (QNAN, SNAN, INF, ZERO, NORM)
- fullClass_o  out  10  RISC-V fclass mask

Behaviour:
- States: IDLE, NORM, DONE.
- Reset (rst_i=1): state IDLE. out_valid_o=0, in_ready_o=1. All data outputs 0.
- flush_i has identical effect to reset, except it does not clear the data outputs. rst_i has priority over flush_i; both have priority over all other events.
- in_ready_o = (state==IDLE). Accept occurs when in_valid_i & in_ready_o. On accept, latch rs1/rm/tag and decode:
  - E=rs1[62:52], F=rs1[51:0].
  - E=0x7FF, F!=0: F[51]=1 is QNAN, F[51]=0 is SNAN. exp=0, sig=0. Next state DONE.
  - E=0x7FF, F=0: INF. exp=0, sig=0. Next state DONE.
  - E=0, F=0: ZERO. exp=0, sig=0. Next state DONE.
  - E in 1..0x7FE: NORM. exp=E-1023, sig={1,F}. Next state DONE.
  - E=0, F!=0: class_o=NORM. exp=-1022, sig={0,F}. Next state NORM.
- NORM, each cycle:
  - lz = leading zeros of sig, clamped to SHIFT_STEP.
  - sig <<= lz; exp -= lz.
  - If lz<SHIFT_STEP, go to DONE; otherwise stay in NORM.
  - Number of NORM cycles N = floor(L/SHIFT_STEP)+1, where L is the initial leading-zero count (1..52).
- Latency: accept at cycle t gives out_valid_o=1 at t+1 for non-subnormals and at t+1+N for subnormals. Smallest subnormal with default SHIFT_STEP: L=52, N=7.
- DONE: out_valid_o=1 and all outputs held stable. When out_ready_i=1, go to IDLE and out_valid_o=0 next cycle. There is no same-cycle re-accept, so maximum throughput is one operand per 2 cycles.
- fullClass_o bit assignments:
  - 0: -inf; 1: -normal; 2: -subnormal; 3: -0
  - 4: +0; 5: +subnormal; 6: +normal; 7: +inf
  - 8: sNaN; 9: qNaN
  - It is computed from the raw operand and reports the true class, including subnormals.
- The exponent never wraps: minimum is -1074, maximum is 1023.

Optional Feature:
- FPU_UNPACK_DAZ_EN defined (denormals-are-zero):
  - Subnormal inputs decode as class ZERO with exp=0, sig=0, and go straight to DONE, giving latency 1.
  - fullClass_o still reports subnormal.
  - The normalizer is still instantiated but unreachable.
- Undefined: subnormals are normalized exactly as above.

Test Plan:
- rs1=0x3FF0000000000000 (1.0) -> exp=0, sig=1<<52, class NORM, fullClass=0x040, out_valid 1 cycle after accept.
- rs1=0x0000000000000001 -> exp=-1074, sig=1<<52, fullClass=0x020, out_valid 8 cycles after accept. With FPU_UNPACK_DAZ_EN: class ZERO, latency 1.
- rs1=0x800FFFFFFFFFFFFF -> exp=-1023, sig=0x1FFFFFFFFFFFFE, fullClass=0x004, N=1, out_valid 2 cycles after accept.
- rs1=0xFFF8000000000000 -> class QNAN, fullClass=0x200. rs1=0x7FF0000000000001 -> class SNAN, fullClass=0x100. rs1=0x8000000000000000 -> class ZERO, fullClass=0x008. exp=0 and sig=0 in all three cases.
- Hold out_ready_i=0 for 3 cycles in DONE -> outputs stable, in_ready_o=0. Then pulse out_ready_i -> next cycle IDLE, then a new operand is accepted.
- Assert rst_i (and separately flush_i) during the 3rd NORM cycle -> next cycle IDLE, out_valid_o=0, in_ready_o=1, no result emitted.
